// File: rtl/poly_compress_seq_if.sv
// Stream/bus bundle for poly_compress_seq: control, coefficient RAM, compress unit and the packed
// output stream. The sequencer takes the master modport, the environment the slave modport.
interface poly_compress_seq_if #(
  parameter int unsigned N_COEF = 256,
  parameter int unsigned OUT_W  = 32
);
  localparam int unsigned AW = $clog2(N_COEF);

  logic             start;
  logic [15:0]      d_in;
  logic             busy;
  logic             done;
  logic             err;
  logic             coef_rd_en;
  logic [AW-1:0]    coef_addr;
  logic [15:0]      coef_rdata;
  logic             cmp_en;
  logic [15:0]      cmp_x;
  logic [15:0]      cmp_d;
  logic [15:0]      cmp_result;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  start, d_in, coef_rdata, cmp_result, out_ready,
    output busy, done, err, coef_rd_en, coef_addr, cmp_en, cmp_x, cmp_d, out_data, out_valid
  );

  modport slave (
    output start, d_in, coef_rdata, cmp_result, out_ready,
    input  busy, done, err, coef_rd_en, coef_addr, cmp_en, cmp_x, cmp_d, out_data, out_valid
  );
endinterface

// File: rtl/poly_compress_seq.sv
// Streams one polynomial through an external compress unit and packs d-bit results LSB-first
// into OUT_W-bit words. Define COMPRESS_D_CHECK_EN to reject d outside {1,4,5,10,11} with err.
module poly_compress_seq #(
  parameter int unsigned N_COEF = 256,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned ACC_W  = 64
) (
  input logic                 clk,
  input logic                 rst,
  poly_compress_seq_if.master bus
);
  localparam int unsigned AW = $clog2(N_COEF);
  localparam int unsigned CW = $clog2(ACC_W + 1);
  localparam int unsigned NW = CW + 2;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           r_state, w_state_next;
  logic [15:0]      r_d;
  logic [AW-1:0]    r_rd_ptr;
  logic             r_inflight;
  logic [ACC_W-1:0] r_acc;
  logic [CW-1:0]    r_acc_cnt;

  logic             w_d_legal, w_accept, w_issue, w_valid, w_pop;
  logic [CW-1:0]    w_cnt_pop, w_acc_cnt_next;
  logic [NW-1:0]    w_dx, w_need;
  logic [15:0]      w_res;
  logic [ACC_W-1:0] w_acc_pop, w_acc_next;

`ifdef COMPRESS_D_CHECK_EN
  logic r_err;
  assign w_d_legal = bus.d_in inside {16'd1, 16'd4, 16'd5, 16'd10, 16'd11};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= (r_state == StIdle) && bus.start && !w_d_legal;
  end
  assign bus.err = r_err;
`else
  assign w_d_legal = 1'b1;
  assign bus.err   = 1'b0;
`endif

  assign w_accept = (r_state == StIdle) && bus.start && w_d_legal;

  // A pop frees OUT_W bits this cycle; the in-flight result and the new read must both still fit.
  assign w_valid   = r_acc_cnt >= CW'(OUT_W);
  assign w_pop     = w_valid && bus.out_ready;
  assign w_cnt_pop = w_pop ? r_acc_cnt - CW'(OUT_W) : r_acc_cnt;
  assign w_dx      = NW'(r_d[4:0]);
  assign w_need    = NW'(w_cnt_pop) + (r_inflight ? (w_dx << 1) : w_dx);
  assign w_issue   = (r_state == StRun) && (w_need <= NW'(ACC_W));

  assign w_res      = bus.cmp_result & ((16'd1 << r_d[4:0]) - 16'd1);
  assign w_acc_pop  = w_pop ? (r_acc >> OUT_W) : r_acc;
  assign w_acc_next = r_inflight ? (w_acc_pop | (ACC_W'(w_res) << w_cnt_pop)) : w_acc_pop;
  assign w_acc_cnt_next = r_inflight ? w_cnt_pop + CW'(r_d[4:0]) : w_cnt_pop;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_accept) w_state_next = StRun;
      StRun:   if (w_issue && (r_rd_ptr == AW'(N_COEF - 1))) w_state_next = StDrain;
      StDrain: if (!r_inflight && (r_acc_cnt == '0) && !w_valid) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_d        <= '0;
      r_rd_ptr   <= '0;
      r_inflight <= 1'b0;
      r_acc      <= '0;
      r_acc_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_inflight <= w_issue;
      r_acc      <= w_acc_next;
      r_acc_cnt  <= w_acc_cnt_next;
      if (w_accept) begin
        r_d      <= bus.d_in;
        r_rd_ptr <= '0;
      end else if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  assign bus.busy       = (r_state == StRun) || (r_state == StDrain);
  assign bus.done       = (r_state == StDone);
  assign bus.coef_rd_en = w_issue;
  assign bus.coef_addr  = r_rd_ptr;
  assign bus.cmp_en     = r_inflight;
  assign bus.cmp_x      = r_inflight ? bus.coef_rdata : 16'd0;
  assign bus.cmp_d      = r_d;
  assign bus.out_data   = r_acc[OUT_W-1:0];
  assign bus.out_valid  = w_valid;
endmodule

// File: tb/tb_poly_compress_seq.sv
// Directed/randomized bench for poly_compress_seq with a RAM model, a compress-unit model and a
// bit-stream reference packer.
`timescale 1ns/1ps
module tb_poly_compress_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  poly_compress_seq_if #(.N_COEF(256), .OUT_W(32)) bus ();

  poly_compress_seq #(.N_COEF(256), .OUT_W(32), .ACC_W(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [256];
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];

  function automatic int compress(input int x, input int d);
    return (((x << d) + 1664) / 3329) % (1 << d);
  endfunction

  always @(posedge clk) if (bus.coef_rd_en) bus.coef_rdata <= mem[bus.coef_addr];

  // Junk above bit d must be ignored by the sequencer.
  always_comb begin
    bus.cmp_result = 16'h0;
    if (bus.cmp_d >= 16'd1 && bus.cmp_d <= 16'd12)
      bus.cmp_result = 16'(compress(int'(bus.cmp_x), int'(bus.cmp_d))) | (16'hBEEF << bus.cmp_d);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic build_exp(input int d);
    bit bits [$];
    int r;
    logic [31:0] v;
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      r = compress(int'(mem[i]), d);
      for (int b = 0; b < d; b++) bits.push_back(r[b]);
    end
    for (int w = 0; w < bits.size() / 32; w++) begin
      for (int b = 0; b < 32; b++) v[b] = bits[32 * w + b];
      exp_q.push_back(v);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_rd_en"}, bus.coef_rd_en, 0);
    check({tag, "_addr"}, bus.coef_addr, 0);
    check({tag, "_cmp_en"}, bus.cmp_en, 0);
    check({tag, "_cmp_x"}, bus.cmp_x, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_data"}, bus.out_data, 0);
  endtask

  // mode 0: out_ready held high; mode 1: ready one cycle in three. abort_at >= 0 resets mid-job.
  task automatic run_job(input int d, input int mode, input int abort_at, output int busy_cyc);
    int cyc = 0, exp_addr = 0, dones = 0, after = 0, prev_addr = 0;
    bit prev_rd = 0, prev_stall = 0;
    logic [31:0] prev_data = '0;
    busy_cyc = 0;
    build_exp(d);
    got_q.delete();
    @(negedge clk);
    bus.start = 1'b1;
    bus.d_in  = 16'(d);
    @(negedge clk);
    bus.d_in  = 16'd3;
    while (after < 4 && cyc < 3000) begin
      bus.out_ready = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
      bus.start = (cyc == 5 || cyc == 0) ? (cyc == 5) : 1'b0;
      #1;
      if (bus.busy) busy_cyc++;
      if (bus.done) dones++;
      if (dones > 0) after++;
      check("cmp_en", bus.cmp_en, prev_rd);
      if (prev_rd) check("cmp_x", bus.cmp_x, mem[prev_addr]);
      if (bus.coef_rd_en) begin
        check("coef_addr", bus.coef_addr, exp_addr);
        prev_addr = exp_addr;
        exp_addr++;
      end
      prev_rd = bus.coef_rd_en;
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, prev_data);
      end
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        rst = 1'b1;
        #1;
        check_idle("abort");
        check("abort_cmp_d", bus.cmp_d, 0);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        dones = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (bus.done) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_busy", bus.busy, 0);
        return;
      end
      cyc++;
      @(negedge clk);
    end
    check("done_count", dones, 1);
    check("addr_total", exp_addr, 256);
    check("word_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("word", got_q[i], exp_q[i]);
  endtask

  int busy_cyc;

  initial begin
    bus.start = 1'b0;
    bus.d_in = 16'd0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    repeat (2) @(negedge clk);
    #1;
    check_idle("reset");
    check("reset_cmp_d", bus.cmp_d, 0);
    rst = 1'b0;

    for (int i = 0; i < 256; i++) mem[i] = 16'd1665;
    run_job(1, 0, -1, busy_cyc);
    if (got_q.size() > 0) check("d1_word0", got_q[0], 32'hFFFF_FFFF);
    check("d1_busy_le_262", busy_cyc <= 262, 1);

    for (int i = 0; i < 256; i++) mem[i] = 16'd0;
    run_job(4, 0, -1, busy_cyc);
    if (got_q.size() > 31) check("d4_word31", got_q[31], 32'h0);

    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    run_job(10, 0, -1, busy_cyc);

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 3328));
    run_job(11, 1, -1, busy_cyc);

    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 3328));
    run_job(5, 0, 10, busy_cyc);
    run_job(5, 0, -1, busy_cyc);

`ifdef COMPRESS_D_CHECK_EN
    @(negedge clk);
    bus.start = 1'b1;
    bus.d_in  = 16'd3;
    #1;
    check("bad_d_rd_en0", bus.coef_rd_en, 0);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check("bad_d_err", bus.err, 1);
    check("bad_d_busy", bus.busy, 0);
    check("bad_d_rd_en1", bus.coef_rd_en, 0);
    @(negedge clk);
    #1;
    check("bad_d_err_pulse", bus.err, 0);
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom_range(0, 3328));
    run_job(4, 0, -1, busy_cyc);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
